// File: rtl/arbiter4_wrr_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
// Contents: arbitration state type, port count, and the rotating
// request scan used by the priority encoder.
package arb_pkg;

  localparam int ARB_PORTS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Returns the first requesting port after ptr, scanning ptr+1, ptr+2,
  // ptr+3 and finally ptr itself. Returns ptr when nothing requests.
  function automatic logic [1:0] rr_next(input logic [1:0] ptr, input logic [3:0] req);
    logic [1:0] idx;
    logic       found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/arbiter4_wrr_rr_pick4.sv
// Combinational rotating priority encoder for four requesters.
// Ports:
//   req  in  4  request vector, bit i = port i
//   ptr  in  2  last holder; scanning starts at ptr+1
//   gnt  out 4  one-hot grant (zero when no request)
//   any  out 1  at least one request present
module rr_pick4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  assign any = |req;
  assign gnt = any ? (4'b0001 << rr_next(ptr, req)) : '0;

endmodule

// File: rtl/arbiter4_wrr.sv
// Four-input weighted round-robin arbiter with registered output stage.
// A newly granted port may move up to max(weight,1) consecutive beats
// before the grant rotates; valid/ready handshake on both sides.
// Ports:
//   clk, rst (sync, active-high)
//   valid_in[3:0], data_in[4*WIDTH-1:0], ready_out[3:0]  upstream ports
//   weight_in[4*WEIGHT_W-1:0]                            per-port burst credit
//   valid_out, data_out[WIDTH-1:0], ready_in             downstream
//   grant_cnt[63:0]  (only with ARB4_WRR_STATS_EN) saturating per-port
//                    transfer counts, 16 bits each
// Build option: ARB4_WRR_STATS_EN adds the grant_cnt port and counters.
module arbiter4_wrr
  import arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            valid_in,
  input  logic [4*WIDTH-1:0]    data_in,
  output logic [3:0]            ready_out,
  input  logic [4*WEIGHT_W-1:0] weight_in,
  output logic                  valid_out,
  output logic [WIDTH-1:0]      data_out,
  input  logic                  ready_in
`ifdef ARB4_WRR_STATS_EN
  ,
  output logic [4*16-1:0]       grant_cnt
`endif
);

  arb_state_t          st;
  logic [1:0]          ptr;
  logic [WEIGHT_W-1:0] cnt;

  logic                ld;
  logic                hold;
  logic                any;
  logic                xfer;
  logic [3:0]          pick_gnt;
  logic [3:0]          gnt;
  logic [1:0]          gidx;
  logic [WIDTH-1:0]    sel_data;
  logic [WEIGHT_W-1:0] sel_w;

  rr_pick4 u_pick (
    .req (valid_in),
    .ptr (ptr),
    .gnt (pick_gnt),
    .any (any)
  );

  assign ld   = ~valid_out | ready_in;
  // The current holder keeps the grant while it still requests.
  assign hold = (st == HOLD) && valid_in[ptr];

  always_comb begin
    gnt      = hold ? (4'b0001 << ptr) : (any ? pick_gnt : '0);
    gidx     = '0;
    sel_data = '0;
    sel_w    = '0;
    for (int unsigned i = 0; i < ARB_PORTS; i++) begin
      if (gnt[i]) begin
        gidx     = 2'(i);
        sel_data = data_in[i*WIDTH +: WIDTH];
        sel_w    = weight_in[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    if (sel_w == '0) sel_w = WEIGHT_W'(1);
  end

  assign ready_out = ld ? gnt : '0;
  assign xfer      = |(valid_in & ready_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      st        <= IDLE;
      ptr       <= 2'd3;
      cnt       <= '0;
    end else if (xfer) begin
      data_out  <= sel_data;
      valid_out <= 1'b1;
      if (hold) begin
        cnt <= cnt - WEIGHT_W'(1);
        if (cnt == WEIGHT_W'(1)) st <= IDLE;
      end else begin
        ptr <= gidx;
        if (sel_w == WEIGHT_W'(1)) begin
          st <= IDLE;
        end else begin
          st  <= HOLD;
          cnt <= sel_w - WEIGHT_W'(1);
        end
      end
    end else begin
      if (valid_out && ready_in) valid_out <= 1'b0;
      // With ld high and no transfer nobody requests, so any burst is over.
      // While ld is low the state is frozen.
      if (ld && st == HOLD && !valid_in[ptr]) st <= IDLE;
    end
  end

`ifdef ARB4_WRR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < ARB_PORTS; i++) begin
        if (valid_in[i] && ready_out[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arbiter4_wrr.sv
// Self-checking bench for arbiter4_wrr with a transaction-level reference
// model (holder port + remaining burst credit + output beat).
module tb_arbiter4_wrr;

  localparam int WIDTH    = 8;
  localparam int WEIGHT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid_in;
  logic [31:0] data_in;
  logic [3:0]  ready_out;
  logic [15:0] weight_in;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        ready_in;
`ifdef ARB4_WRR_STATS_EN
  logic [63:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  arbiter4_wrr #(.WIDTH(WIDTH), .WEIGHT_W(WEIGHT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .weight_in (weight_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in)
`ifdef ARB4_WRR_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_ptr;
  int         m_left;   // beats still allowed to the holder after the last one
  bit         m_vo;
  logic [7:0] m_do;
  logic [3:0] e_rdy;
  int         e_g;
  bit         e_ld;

  task automatic model_reset();
    m_ptr  = 3;
    m_left = 0;
    m_vo   = 0;
    m_do   = '0;
  endtask

  task automatic model_eval();
    e_ld = !m_vo || ready_in;
    e_g  = -1;
    if (m_left > 0 && valid_in[m_ptr]) e_g = m_ptr;
    else
      for (int k = 1; k <= 4; k++)
        if (e_g < 0 && valid_in[(m_ptr + k) % 4]) e_g = (m_ptr + k) % 4;
    e_rdy = (e_ld && e_g >= 0) ? 4'(1 << e_g) : 4'b0000;
  endtask

  task automatic tick();
    int w;
    model_eval();
    @(posedge clk);
    if (rst) model_reset();
    else if (e_rdy != 0) begin
      m_do = data_in[e_g*8 +: 8];
      m_vo = 1;
      if (m_left > 0 && e_g == m_ptr) m_left--;
      else begin
        w = int'(weight_in[e_g*4 +: 4]);
        if (w == 0) w = 1;
        m_ptr  = e_g;
        m_left = w - 1;
      end
    end else begin
      if (m_vo && ready_in) m_vo = 0;
      if (e_ld) m_left = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; valid_in = '0; ready_in = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; valid_in = '0; ready_in = 1; weight_in = 16'h1111; data_in = $urandom;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({ready_out, valid_out, data_out} !== 13'd0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vo=%b do=%h, want 0/0/00", ready_out, valid_out, data_out);
    end
    rst = 0;
    model_reset();
  endtask

  task automatic test_rotation();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    weight_in = 16'h1111; valid_in = 4'b1111; ready_in = 1; data_in = 32'h44332211;
    for (int c = 0; c < 8; c++) begin
      model_eval();
      @(negedge clk);
      checks++;
      if ({ready_out, valid_out, data_out} !== {e_rdy, m_vo, m_do}) begin
        errors++;
        $display("FAIL rotation c%0d: got rdy=%b vo=%b do=%h, want rdy=%b vo=%b do=%h",
                 c, ready_out, valid_out, data_out, e_rdy, m_vo, m_do);
      end
      if (c < 5) begin
        checks++;
        if (ready_out !== 4'(1 << order[c])) begin
          errors++;
          $display("FAIL rotation_order c%0d: got %b, want port %0d", c, ready_out, order[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_weighted();
    int order[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    do_reset();
    weight_in = 16'h1113; valid_in = 4'b1111; ready_in = 1; data_in = 32'hD4C3B2A1;
    for (int c = 0; c < 9; c++) begin
      model_eval();
      @(negedge clk);
      checks++;
      if (ready_out !== 4'(1 << order[c]) || {valid_out, data_out} !== {m_vo, m_do}) begin
        errors++;
        $display("FAIL weighted c%0d: got rdy=%b vo=%b do=%h, want port %0d vo=%b do=%h",
                 c, ready_out, valid_out, data_out, order[c], m_vo, m_do);
      end
      tick();
    end
  endtask

  task automatic test_holder_drop();
    logic [3:0] want[8] = '{4'b0001, 4'b0001, 4'b0100, 4'b0001,
                            4'b0001, 4'b0001, 4'b0001, 4'b0100};
    do_reset();
    weight_in = 16'h1114; ready_in = 1; data_in = 32'h77665544;
    for (int c = 0; c < 8; c++) begin
      valid_in = (c == 2) ? 4'b0100 : 4'b0101;
      model_eval();
      @(negedge clk);
      checks++;
      if (ready_out !== want[c] || {ready_out, valid_out, data_out} !== {e_rdy, m_vo, m_do}) begin
        errors++;
        $display("FAIL holder_drop c%0d: got rdy=%b vo=%b do=%h, want rdy=%b vo=%b do=%h",
                 c, ready_out, valid_out, data_out, want[c], m_vo, m_do);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [3:0] want[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    do_reset();
    weight_in = 16'h2222; valid_in = 4'b1111; data_in = 32'h0F0E0D0C;
    for (int c = 0; c < 6; c++) begin
      ready_in = !(c >= 1 && c <= 3);
      model_eval();
      @(negedge clk);
      checks++;
      if (ready_out !== want[c] || {ready_out, valid_out, data_out} !== {e_rdy, m_vo, m_do}) begin
        errors++;
        $display("FAIL stall c%0d: got rdy=%b vo=%b do=%h, want rdy=%b vo=%b do=%h",
                 c, ready_out, valid_out, data_out, want[c], m_vo, m_do);
      end
      tick();
    end
    ready_in = 1;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    weight_in = 16'h1511; valid_in = 4'b0100; ready_in = 1; data_in = 32'h99887766;
    tick(); tick(); tick();
    rst = 1; valid_in = 4'b1111;
    tick();
    rst = 0;
    model_eval();
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_burst: got vo=%b rdy=%b, want vo=0 rdy=0001", valid_out, ready_out);
    end
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    weight_in = 16'h2131; valid_in = '0; ready_in = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(valid_in[i] && !e_rdy[i])) begin
          valid_in[i] = ($urandom_range(0, 3) != 0);
          data_in[i*8 +: 8] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) weight_in[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(0, 5));
      ready_in = ($urandom_range(0, 3) != 0);
      model_eval();
      @(negedge clk);
      checks++;
      if ({ready_out, valid_out, data_out} !== {e_rdy, m_vo, m_do}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random c%0d: got rdy=%b vo=%b do=%h, want rdy=%b vo=%b do=%h",
                   c, ready_out, valid_out, data_out, e_rdy, m_vo, m_do);
        bad++;
      end
      tick();
    end
  endtask

`ifdef ARB4_WRR_STATS_EN
  task automatic test_stats();
    do_reset();
    valid_in = 4'b0010; ready_in = 1; weight_in = 16'h1111;
    for (int c = 0; c < 70000; c++) tick();
    @(negedge clk);
    checks++;
    if (grant_cnt !== 64'h0000_0000_FFFF_0000) begin
      errors++;
      $display("FAIL stats: got %h, want 00000000ffff0000", grant_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1; valid_in = '0; ready_in = 1; weight_in = 16'h1111; data_in = '0;
    model_reset();
    test_reset();
    test_rotation();
    test_weighted();
    test_holder_drop();
    test_stall();
    test_reset_mid_burst();
    test_random();
`ifdef ARB4_WRR_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
